// File: rtl/oam_dma_arbiter_pkg.sv
// Shared typedefs and address defaults for the CPU/OAM-DMA bus arbiter.
// The ALIGN state is only reachable when NESV_DMA_ALIGN_EN is defined.
package oam_dma_arbiter_pkg;

  localparam logic [15:0] DMA_REG_ADDR_DEFAULT  = 16'h4014;
  localparam logic [15:0] OAM_DATA_ADDR_DEFAULT = 16'h2004;
  localparam int          XFER_LEN_DEFAULT      = 256;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    HALT  = 3'd1,
    ALIGN = 3'd2,
    READ  = 3'd3,
    WRITE = 3'd4
  } dma_state_t;

  // One bus access as seen by the memory map.
  typedef struct packed {
    logic [15:0] addr;
    logic        rw;
    logic [7:0]  wdata;
  } bus_req_t;

  function automatic bus_req_t make_req(input logic [15:0] addr, input logic rw,
                                        input logic [7:0] wdata);
    bus_req_t r;
    r.addr  = addr;
    r.rw    = rw;
    r.wdata = wdata;
    return r;
  endfunction

endpackage

// File: rtl/oam_dma_arbiter.sv
// Shares the CPU system bus between the 6502 core and the sprite OAM DMA engine.
// Define NESV_DMA_ALIGN_EN to add the odd-cycle ALIGN dummy read before the copy.
module oam_dma_arbiter
  import oam_dma_arbiter_pkg::*;
#(
  parameter logic [15:0] DMA_REG_ADDR  = DMA_REG_ADDR_DEFAULT,
  parameter logic [15:0] OAM_DATA_ADDR = OAM_DATA_ADDR_DEFAULT,
  parameter int          XFER_LEN      = XFER_LEN_DEFAULT
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [15:0] cpu_addr,
  input  logic        cpu_rw,
  input  logic [7:0]  cpu_wdata,
  output logic [7:0]  cpu_rdata,
  output logic        cpu_halt,
  output logic [15:0] bus_addr,
  output logic        bus_rw,
  output logic [7:0]  bus_wdata,
  input  logic [7:0]  bus_rdata,
  output logic        dma_busy
);

  // XFER_LEN is a power of two no larger than 256, so the last index fits in idx.
  localparam logic [7:0] IDX_LAST = 8'(XFER_LEN - 1);

  dma_state_t  state_reg, state_next;
  logic [7:0]  idx_reg;
  logic [7:0]  page_reg;
  logic [7:0]  data_buf_reg;
  logic [15:0] last_addr_reg;
  logic        trigger;
  logic        idx_last;
  bus_req_t    bus_req;

  assign trigger  = (cpu_rw == 1'b0) && (cpu_addr == DMA_REG_ADDR);
  assign idx_last = (idx_reg == IDX_LAST);

`ifdef NESV_DMA_ALIGN_EN
  logic cycle_odd_reg;

  always_ff @(posedge clk) begin
    if (reset) begin
      cycle_odd_reg <= 1'b0;
    end else begin
      cycle_odd_reg <= ~cycle_odd_reg;
    end
  end
`endif

  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg <= IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE: begin
        if (trigger) begin
          state_next = HALT;
        end
      end
      HALT: begin
`ifdef NESV_DMA_ALIGN_EN
        state_next = cycle_odd_reg ? ALIGN : READ;
`else
        state_next = READ;
`endif
      end
      ALIGN:   state_next = READ;
      READ:    state_next = WRITE;
      WRITE:   state_next = idx_last ? IDLE : READ;
      default: state_next = IDLE;
    endcase
  end

  // Re-trigger writes are ignored outside IDLE because only IDLE looks at trigger.
  always_ff @(posedge clk) begin
    if (reset) begin
      idx_reg       <= 8'd0;
      page_reg      <= 8'd0;
      data_buf_reg  <= 8'd0;
      last_addr_reg <= 16'd0;
    end else begin
      case (state_reg)
        IDLE: begin
          last_addr_reg <= cpu_addr;
          if (trigger) begin
            page_reg <= cpu_wdata;
            idx_reg  <= 8'd0;
          end
        end
        READ: begin
          data_buf_reg <= bus_rdata;
        end
        WRITE: begin
          idx_reg <= idx_last ? 8'd0 : idx_reg + 8'd1;
        end
        default: begin
        end
      endcase
    end
  end

  // Bus mux: CPU passes straight through in IDLE; DMA owns the bus otherwise.
  always_comb begin
    bus_req  = make_req(cpu_addr, cpu_rw, cpu_wdata);
    cpu_halt = 1'b0;
    case (state_reg)
      IDLE: begin
      end
      HALT, ALIGN: begin
        bus_req  = make_req(last_addr_reg, 1'b1, 8'd0);
        cpu_halt = 1'b1;
      end
      READ: begin
        bus_req  = make_req({page_reg, idx_reg}, 1'b1, 8'd0);
        cpu_halt = 1'b1;
      end
      WRITE: begin
        bus_req  = make_req(OAM_DATA_ADDR, 1'b0, data_buf_reg);
        cpu_halt = 1'b1;
      end
      default: begin
      end
    endcase
  end

  assign bus_addr  = bus_req.addr;
  assign bus_rw    = bus_req.rw;
  assign bus_wdata = bus_req.wdata;
  assign cpu_rdata = bus_rdata;
  assign dma_busy  = (state_reg != IDLE);

endmodule

// File: doc/oam_dma_arbiter.md
Name: oam_dma_arbiter

Overview:
- Shares the single CPU system bus between the 6502 core and the sprite OAM DMA engine.
- A CPU write to the DMA register starts the transfer. The block then stalls the CPU and copies 256 bytes from page $XX00–$XXFF to the OAM data port, after which it returns the bus to the CPU.
- Sits between the cpu core and the address decoder / memory map.
- Pass-through is combinational when idle.

Parameters:
- DMA_REG_ADDR, 16'h4014: CPU write address that triggers DMA; the written byte is the source page.
- OAM_DATA_ADDR, 16'h2004: destination address for every DMA write.
- XFER_LEN, 256: bytes per transfer; must be a power of two, at most 256.

Ports:
- clk  in  1  system clock; single clock domain.
- reset  in  1  synchronous, active-high reset.
- cpu_addr  in  16  CPU address.
- cpu_rw  in  1  CPU direction; 1 = read, 0 = write.
- cpu_wdata  in  8  CPU write data.
- cpu_rdata  out  8  read data returned to the CPU; always equals bus_rdata.
- cpu_halt  out  1  1 = CPU must not advance its state this cycle.
- bus_addr  out  16  address to the memory map.
- bus_rw  out  1  bus direction; 1 = read.
- bus_wdata  out  8  bus write data.
- bus_rdata  in  8  bus read data.
- dma_busy  out  1  1 whenever state != IDLE.

Behaviour:
- Clocking and reset: one clock, clk. Reset is synchronous and active-high. On reset:
  - state=IDLE, idx=0, page=0, data_buf=0, cycle_odd=0.
  - cpu_halt=0, dma_busy=0; the bus passes CPU signals through.
- cycle_odd: toggles every clk edge while out of reset, independent of state. Its value during a cycle defines that cycle's parity.
- IDLE:
  - bus_addr/bus_rw/bus_wdata = cpu_addr/cpu_rw/cpu_wdata, combinationally.
  - cpu_halt=0.
  - If cpu_rw=0 and cpu_addr==DMA_REG_ADDR at a posedge: page<=cpu_wdata, idx<=0, state<=HALT.
  - The triggering write itself still reaches the bus.
- HALT (1 cycle):
  - cpu_halt=1.
  - Bus performs a dummy read: bus_addr=held last CPU address, bus_rw=1.
  - Next state: ALIGN if cycle_odd==1 in this cycle, else READ.
- ALIGN (1 cycle): same dummy read as HALT; next state is READ.
- READ:
  - bus_addr={page,idx}, bus_rw=1.
  - data_buf<=bus_rdata at the posedge; next state is WRITE.
- WRITE:
  - bus_addr=OAM_DATA_ADDR, bus_rw=0, bus_wdata=data_buf.
  - If idx==XFER_LEN-1: next state is IDLE; idx<=0.
  - Otherwise: idx<=idx+1; next state is READ.
- Halt and busy: cpu_halt=1 and dma_busy=1 in every non-IDLE state. cpu_halt drops in the first IDLE cycle after the final WRITE.
- Cycle counts:
  - Trigger write at cycle N; halt is first asserted at N+1.
  - Total halted cycles = 1 + align + 2*XFER_LEN = 513 or 514.
- Boundary conditions:
  - Writes to DMA_REG_ADDR while not IDLE are ignored; the CPU is halted anyway.
  - idx is 8 bits wide. The source address never crosses the page: after $XXFF the transfer ends and never reads $XX+1,00.
  - Page $FF is legal; the last source read is $FFFF.
  - Reset mid-transfer: state returns to IDLE in the next cycle and the partial transfer is abandoned. Bytes already written remain written.
- cpu_rdata is always bus_rdata; the CPU ignores it while halted.

Optional Feature:
- Macro: NESV_DMA_ALIGN_EN.
- Defined: ALIGN state is present; transfers take 513 halted cycles when started on an even-parity HALT cycle, 514 otherwise.
- Undefined: ALIGN state and cycle_odd are removed. HALT always goes to READ; transfers always take 513 cycles.

Decomposition:
- Shared package (alongside the existing common typedefs):
  - dma_state_t enum {IDLE, HALT, ALIGN, READ, WRITE}.
  - Constants for DMA_REG_ADDR and OAM_DATA_ADDR defaults.
- No sub-module; the bus mux is a single always_comb inside the block.

Test Plan:
- Idle pass-through: CPU read $8000 -> bus_addr=$8000, bus_rw=1, cpu_halt=0. CPU write $55 to $0200 -> bus_wdata=$55, bus_rw=0.
- Basic DMA, even parity: write $02 to $4014 with cycle_odd=1 at the trigger (HALT sees 0).
  - Halt is asserted for 513 cycles.
  - Reads go to $0200..$02FF; 256 writes go to $2004 with the matching bytes.
  - cpu_halt=0 on cycle 514.
- Odd parity with NESV_DMA_ALIGN_EN defined: trigger so HALT sees cycle_odd=1 -> 514 halted cycles and exactly one extra dummy read. With the macro undefined, the same stimulus gives 513.
- Page $FF: last read is $FFFF, followed by a write to $2004, then IDLE; no access to $0000.
- Re-trigger: a write to $4014 during the transfer (forced on the CPU side) is ignored; page and idx are unchanged.
- Reset at idx=$40 in READ -> next cycle: IDLE, cpu_halt=0, dma_busy=0, bus mirrors the CPU. A new trigger then restarts from idx=0.
